// File: rtl/myproject_mul_share_pkg.sv
// Shared-multiplier arbiter package: default operand/product widths, request
// and response records, and the signed saturation limits of the product.
package myproject_mul_share_pkg;

  localparam int A_W_DEF  = 33;
  localparam int B_W_DEF  = 11;
  localparam int P_W_DEF  = 36;
  localparam int ID_W_MAX = 4;   // enough for up to 16 requesters

  // One issued multiply: signed A, zero-extended B, issuing requester
  typedef struct packed {
    logic signed [A_W_DEF-1:0] a;
    logic        [B_W_DEF:0]   b;
    logic        [ID_W_MAX-1:0] id;
  } mul_req_t;

  // One delivered product with its tag
  typedef struct packed {
    logic        [ID_W_MAX-1:0] id;
    logic signed [P_W_DEF-1:0]  data;
  } mul_rsp_t;

  localparam logic signed [P_W_DEF-1:0] SAT_MAX = {1'b0, {(P_W_DEF-1){1'b1}}};
  localparam logic signed [P_W_DEF-1:0] SAT_MIN = {1'b1, {(P_W_DEF-1){1'b0}}};

endpackage

// File: rtl/myproject_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
// The pointer moves to the winner only when a grant is issued.
module myproject_rr_arbiter
  import myproject_mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  logic [ID_W-1:0] rr_ptr;

  // Pick the first active requester after the pointer, wrapping around
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (en) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % N_REQ;
        if (!grant_any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = ID_W'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

  // Remember the last winner; restart so requester 0 is searched first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= ID_W'(N_REQ - 1);
    end else if (grant_any) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// Shared signed x unsigned multiplier with round-robin request arbitration,
// valid/ready on both sides and a two-stage registered pipeline.
// Build option MUL_SHARE_ARB_SAT_EN: saturate the product to the signed
// P_W range instead of keeping its low P_W bits. Latency is unchanged.
module myproject_mul_share_arb
  import myproject_mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int P_W   = P_W_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*A_W-1:0]    req_a,
  input  logic [N_REQ*B_W-1:0]    req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic signed [P_W-1:0]   rsp_data
);

  localparam int FULL_W = A_W + B_W + 1;

  // Reduce the full product to P_W bits: wrap, or clamp when saturating
  function automatic logic signed [P_W-1:0] fit_p(input logic signed [FULL_W-1:0] full);
`ifdef MUL_SHARE_ARB_SAT_EN
    logic signed [FULL_W-1:0] hi;
    logic signed [FULL_W-1:0] lo;
    hi = {{(FULL_W-P_W+1){1'b0}}, {(P_W-1){1'b1}}};
    lo = ~hi;
    if (full > hi) begin
      fit_p = {1'b0, {(P_W-1){1'b1}}};
    end else if (full < lo) begin
      fit_p = {1'b1, {(P_W-1){1'b0}}};
    end else begin
      fit_p = full[P_W-1:0];
    end
`else
    fit_p = full[P_W-1:0];
`endif
  endfunction

  logic                    vld_p1, vld_p2;
  logic signed [A_W-1:0]   a_p0, a_p1;
  logic        [B_W-1:0]   b_p0;
  logic signed [B_W:0]     b_p1;
  logic [ID_W-1:0]         id_p1, id_p2;
  logic signed [FULL_W-1:0] full_p1;
  logic signed [P_W-1:0]   data_p2;
  logic                    s1_adv, s2_adv;
  logic [N_REQ-1:0]        grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_any;

  // Output stage loads when empty or draining; stage 1 loads when it can pass on
  assign s2_adv = !vld_p2 || rsp_ready;
  assign s1_adv = !vld_p1 || s2_adv;

  myproject_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .req       (req_valid),
    .en        (s1_adv && ap_rst_n),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // ---- p0 -> p1: select the winning requester's operands ----
  assign a_p0 = $signed(req_a[grant_idx*A_W +: A_W]);
  assign b_p0 = req_b[grant_idx*B_W +: B_W];

  // Stage-1 occupancy
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= grant_any;
    end
  end

  // Stage-1 operands, captured only on an accepted request
  always_ff @(posedge ap_clk) begin
    if (s1_adv && grant_any) begin
      a_p1  <= a_p0;
      b_p1  <= $signed({1'b0, b_p0});
      id_p1 <= grant_idx;
    end
  end

  // ---- p1 -> p2: multiply, reduce to P_W, register as the response ----
  assign full_p1 = a_p1 * b_p1;

  // Response register; holds steady while the consumer stalls
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_p2  <= 1'b0;
      id_p2   <= '0;
      data_p2 <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        id_p2   <= id_p1;
        data_p2 <= fit_p(full_p1);
      end
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_id    = id_p2;
  assign rsp_data  = data_p2;

endmodule
